fetch_unit: RTL and testbench

Instruction fetch stage that sits in front of `decoder`. It generates sequential PCs, issues requests to instruction memory over a valid/ready handshake, and buffers the returned words in an in-order FIFO. It presents `instr`/`instr_pc` to the decoder over a valid/ready handshake. A redirect (taken branch, `jump`, `jumpReg`) flushes the buffer, discards stale in-flight responses and restarts fetch at the new target.

---
 rtl/fetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage in front of the decoder.
//
// Generates sequential fetch PCs, issues them to instruction memory over a
// valid/ready request channel, and buffers returned words (with their PCs)
// in an in-order FIFO presented to the decoder over valid/ready. A redirect
// flushes the FIFO, discards responses still owed to older requests and
// restarts fetch at the new target.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   imem_req_valid/ready/addr       request channel (addr = current fetch PC)
//   imem_resp_valid/data            in-order response channel
//   instr_valid/ready, instr, instr_pc   FIFO head towards the decoder
//   redirect, redirect_pc           control-flow change and new target
//   misaligned                      fetch fault flag
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined     : a misaligned redirect target enters a sticky FAULT state.
//   not defined : the target is forced word-aligned, misaligned is tied 0.

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misaligned
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic {ST_FETCH, ST_FAULT} state_e;
`else
  typedef enum logic {ST_FETCH} state_e;
`endif

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]   fifo_head_q, fifo_head_d;
  logic [PTR_W-1:0]   fifo_tail_q, fifo_tail_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [PTR_W-1:0]   aq_head_q, aq_head_d;
  logic [PTR_W-1:0]   aq_tail_q, aq_tail_d;

  // Word/PC storage and the queue of issued addresses. Outstanding requests
  // never exceed FIFO_DEPTH, so the address queue needs the same depth.
  logic [31:0] fifo_data_q [FIFO_DEPTH];
  logic [31:0] fifo_pc_q   [FIFO_DEPTH];
  logic [31:0] aq_addr_q   [FIFO_DEPTH];

  logic        req_fire;
  logic        pop;
  logic        resp_keep;
  logic [CNT_W:0] used_slots;
  logic [31:0] target;
  logic        target_bad;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target     = redirect_pc;
  assign target_bad = (redirect_pc[1:0] != 2'b00);
  assign misaligned = (state_q == ST_FAULT);
`else
  assign target     = redirect_pc & ~32'h0000_0003;
  assign target_bad = 1'b0;
  assign misaligned = 1'b0;
`endif

  // Credit check counts words buffered plus words still in flight, so every
  // response is guaranteed a free FIFO slot.
  assign used_slots     = (CNT_W+1)'(fifo_count_q) + (CNT_W+1)'(outstanding_q);
  assign imem_req_valid = !reset && (state_q == ST_FETCH) && !redirect &&
                          (used_slots < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid = (fifo_count_q != '0);
  assign instr       = instr_valid ? fifo_data_q[fifo_head_q] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc_q[fifo_head_q]   : 32'h0;
  assign pop         = instr_valid && instr_ready;

  // A response is kept only if it belongs to a live request and no flush is
  // happening in the same cycle.
  assign resp_keep = imem_resp_valid && (drop_q == '0) && !redirect &&
                     (state_q == ST_FETCH);

  // NOTE: every _d signal gets its default from the matching _q first, so no
  // path through this block leaves a variable unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fifo_count_d  = fifo_count_q;
    fifo_head_d   = fifo_head_q;
    fifo_tail_d   = fifo_tail_q;
    aq_head_d     = aq_head_q;
    aq_tail_d     = aq_tail_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

    if (req_fire) begin
      pc_d      = pc_q + 32'd4;
      aq_tail_d = ptr_inc(aq_tail_q);
    end
    if (imem_resp_valid) begin
      aq_head_d = ptr_inc(aq_head_q);
      if (drop_q != '0) drop_d = drop_q - 1'b1;
    end

    if (pop) begin
      fifo_head_d  = ptr_inc(fifo_head_q);
      fifo_count_d = fifo_count_d - 1'b1;
    end
    if (resp_keep) begin
      fifo_tail_d  = ptr_inc(fifo_tail_q);
      fifo_count_d = fifo_count_d + 1'b1;
    end

    // Redirect: everything still in flight is stale, including a response
    // arriving this very cycle (already excluded from outstanding_d).
    if (redirect && (state_q == ST_FETCH)) begin
      fifo_count_d = '0;
      fifo_head_d  = '0;
      fifo_tail_d  = '0;
      pc_d         = target;
      drop_d       = outstanding_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (target_bad) state_d = ST_FAULT;
`endif
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      fifo_count_q  <= '0;
      fifo_head_q   <= '0;
      fifo_tail_q   <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      aq_head_q     <= '0;
      aq_tail_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fifo_count_q  <= fifo_count_d;
      fifo_head_q   <= fifo_head_d;
      fifo_tail_q   <= fifo_tail_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      aq_head_q     <= aq_head_d;
      aq_tail_q     <= aq_tail_d;
    end
  end

  // NOTE: storage arrays are not reset; an entry is only ever read after it
  // was written, because validity is tracked by the reset counters above.
  always_ff @(posedge clk) begin
    if (req_fire) aq_addr_q[aq_tail_q] <= pc_q;
    if (resp_keep) begin
      fifo_data_q[fifo_tail_q] <= imem_resp_data;
      fifo_pc_q[fifo_tail_q]   <= aq_addr_q[aq_head_q];
    end
  end

  logic unused_target_bad;
  assign unused_target_bad = target_bad;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based model of the fetch
// stage is compared against the DUT every cycle, plus directed scenarios
// with literal expectations. A second instance checks RESET_PC wrap.

module tb_fetch_unit;

  localparam int          D      = 3;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_SW   = 32'h0050A223;

  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misaligned;

  logic        w_req_valid, w_instr_valid, w_misaligned;
  logic [31:0] w_req_addr, w_instr, w_instr_pc;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .misaligned(misaligned)
  );

  // Idle instance: no responses, nothing consumed, so it issues exactly
  // FIFO_DEPTH sequential requests starting at its RESET_PC.
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr),
    .imem_resp_valid(1'b0), .imem_resp_data(32'h0),
    .instr_valid(w_instr_valid), .instr_ready(1'b0),
    .instr(w_instr), .instr_pc(w_instr_pc),
    .redirect(1'b0), .redirect_pc(32'h0),
    .misaligned(w_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;
  typedef struct { int cyc; logic [31:0] pc; logic [31:0] data; } log_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   lat = 1;
  bit   armed = 0;

  // Model state
  logic [31:0] m_pc;
  ent_t        m_fifo[$];
  req_t        m_infl[$];
  bit          m_fault = 0;

  mem_t        mem_q[$];
  bit          acc;
  logic [31:0] acc_addr;
  log_t        req_log[$];
  log_t        con_log[$];
  logic [31:0] w_log[$];

  bit   fire, pop;
  req_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return I_ADD;
      32'h4:   return I_LW;
      32'h8:   return I_SW;
      default: return ~a;
    endcase
  endfunction

  function automatic bit m_req_valid();
    return !reset && !m_fault && !redirect && ((m_fifo.size() + m_infl.size()) < D);
  endfunction

  // Model update + memory behaviour at the active edge (inputs are stable).
  always @(posedge clk) begin
    fire = m_req_valid() && imem_req_ready;
    pop  = (m_fifo.size() > 0) && instr_ready;
    if (reset) begin
      m_pc = RST_PC;
      m_fifo.delete();
      m_infl.delete();
      m_fault = 0;
      armed = 1;
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (imem_resp_valid && m_infl.size() > 0) begin
        e = m_infl.pop_front();
        if (!e.stale && !redirect && !m_fault) m_fifo.push_back('{e.addr, mem_word(e.addr)});
      end
      if (fire) begin
        m_infl.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (redirect && !m_fault) begin
        m_fifo.delete();
        foreach (m_infl[i]) m_infl[i].stale = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
        m_pc = redirect_pc;
        if (redirect_pc[1:0] != 2'b00) m_fault = 1;
`else
        m_pc = {redirect_pc[31:2], 2'b00};
`endif
      end
    end
    if (reset) mem_q.delete();
    else begin
      if (imem_resp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (acc) mem_q.push_back('{acc_addr, cyc + lat});
    end
    cyc++;
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  end

  // Sampling, logging and per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    acc      = imem_req_valid && imem_req_ready && !reset;
    acc_addr = imem_req_addr;
    if (!reset) begin
      if (imem_req_valid && imem_req_ready) req_log.push_back('{cyc, imem_req_addr, 32'h0});
      if (instr_valid && instr_ready) con_log.push_back('{cyc, instr_pc, instr});
      if (armed && w_req_valid && w_log.size() < 4) w_log.push_back(w_req_addr);
    end
    if (armed) begin
      check("req_valid", imem_req_valid, m_req_valid());
      check("req_addr", imem_req_addr, m_pc);
      check("instr_valid", instr_valid, m_fifo.size() > 0);
      if (m_fifo.size() > 0) begin
        check("instr", instr, m_fifo[0].data);
        check("instr_pc", instr_pc, m_fifo[0].pc);
      end
      check("misaligned", misaligned, m_fault);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input int latency);
    reset    = 1'b1;
    redirect = 1'b0;
    step(2);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_misaligned", misaligned, 0);
    lat   = latency;
    reset = 1'b0;
    req_log.delete();
    con_log.delete();
  endtask

  task automatic find_con(input int c, output log_t ent);
    bit found;
    found = 0;
    ent   = '{-1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < con_log.size(); i++)
      if (!found && con_log[i].cyc >= c) begin
        ent   = con_log[i];
        found = 1;
      end
  endtask

  initial begin
    int   rel, rc, k, cnt;
    log_t ent;
    logic [31:0] exp_pc, r;
    logic [31:0] prog [3];
    prog[0] = I_ADD; prog[1] = I_LW; prog[2] = I_SW;

    reset = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;

    // Sequential fetch with single-cycle memory.
    do_reset(1);
    rel = cyc;
    step(10);
    check("t1_first_req_cyc", req_log[0].cyc, rel);
    check("t1_first_req_addr", req_log[0].pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("t1_con_cyc", con_log[i].cyc, rel + 2 + i);
      check("t1_con_pc", con_log[i].pc, 4 * i);
      check("t1_con_word", con_log[i].data, prog[i]);
    end
    check("wrap_addr0", w_log[0], 32'hFFFF_FFF8);
    check("wrap_addr1", w_log[1], 32'hFFFF_FFFC);
    check("wrap_addr2", w_log[2], 32'h0000_0000);
    check("wrap_addr3", w_log[3], 32'h0000_0004);

    // Decoder stalled: only FIFO_DEPTH requests may be issued.
    instr_ready = 1'b0;
    do_reset(1);
    step(8);
    check("t2_req_count", req_log.size(), D);
    check("t2_req_held_low", imem_req_valid, 0);
    instr_ready = 1'b1;
    step(8);
    for (int i = 0; i < D + 1; i++) check("t2_order_pc", con_log[i].pc, 4 * i);

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset(3);
    k = 0;
    while (k < 20 && m_infl.size() != 2) begin
      step(1);
      k++;
    end
    check("t3_two_outstanding", m_infl.size(), 2);
    redirect = 1'b1; redirect_pc = 32'h100; rc = cyc;
    step(1);
    redirect = 1'b0;
    step(12);
    find_con(rc, ent);
    check("t3_pc_after_redirect", ent.pc, 32'h100);
    check("t3_word_after_redirect", ent.data, 32'hFFFF_FEFF);

    // Redirect coinciding with a response and a consumer pop.
    do_reset(1);
    step(4);
    k = 0;
    while (k < 20 && !(imem_resp_valid && m_fifo.size() > 0)) begin
      step(1);
      k++;
    end
    check("t4_precondition", imem_resp_valid && instr_valid, 1);
    exp_pc = m_fifo[0].pc;
    redirect = 1'b1; redirect_pc = 32'h200; rc = cyc;
    step(1);
    redirect = 1'b0;
    check("t4_fifo_empty_after", instr_valid, 0);
    find_con(rc, ent);
    check("t4_pop_cyc", ent.cyc, rc);
    check("t4_pop_pc", ent.pc, exp_pc);
    step(6);
    find_con(rc + 1, ent);
    check("t4_pc_after_redirect", ent.pc, 32'h200);

    // Misaligned redirect target.
    do_reset(1);
    step(4);
    redirect = 1'b1; redirect_pc = 32'h102; rc = cyc;
    step(1);
    redirect = 1'b0;
    step(8);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("t5_misaligned_set", misaligned, 1);
    cnt = 0;
    foreach (req_log[i]) if (req_log[i].cyc > rc) cnt++;
    check("t5_no_req_in_fault", cnt, 0);
    check("t5_fifo_empty", instr_valid, 0);
`else
    find_con(rc + 1, ent);
    check("t5_aligned_target", ent.pc, 32'h100);
    check("t5_misaligned_zero", misaligned, 0);
`endif

    // Randomised traffic against the model.
    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      r              = $urandom;
      imem_req_ready = (r[1:0] != 2'b00);
      instr_ready    = (r[4:2] != 3'b000);
      redirect       = (r[9:6] == 4'hF);
      redirect_pc    = {20'h0, r[21:12], 2'b00};
      step(1);
    end
    redirect = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    step(10);
    check("w_never_valid", w_instr_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
